// File: rtl/decode_stage.sv
// Single-issue RV decode stage: combinational field/immediate decode feeding a
// two-entry (output + skid) elastic buffer with registered, out_ready-independent in_ready.
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [6:0]      funct7,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            rs1_used,
  output logic            rs2_used,
  output logic            rd_we,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_we;
    logic            illegal;
  } bundle_t;

  bundle_t     dec;
  bundle_t     out_q;
  bundle_t     skid_q;
  logic        out_valid_q;
  logic        skid_valid;
  logic [31:0] imm32;
  logic        accept;

  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[6:0];
    dec.funct7 = in_instr[31:25];
    dec.funct3 = in_instr[14:12];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];

    // Every mapped opcode ends in 2'b11, so non-32-bit encodings fall to default.
    case (in_instr[6:0])
      7'b0110011: dec.fmt = FMT_R;
      7'b0111011: if (XLEN == 64) dec.fmt = FMT_R; else dec.fmt = FMT_NONE;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: dec.fmt = FMT_I;
      7'b0011011: if (XLEN == 64) dec.fmt = FMT_I; else dec.fmt = FMT_NONE;
      7'b0100011: dec.fmt = FMT_S;
      7'b1100011: dec.fmt = FMT_B;
      7'b0110111, 7'b0010111: dec.fmt = FMT_U;
      7'b1101111: dec.fmt = FMT_J;
      default:    dec.fmt = FMT_NONE;
    endcase

    case (dec.fmt)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec.imm = XLEN'($signed(imm32));

    dec.rs1_used = (dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) &&
                   !(in_instr[6:0] == 7'b1110011 && in_instr[14:12] == 3'b000);
    dec.rs2_used = dec.fmt inside {FMT_R, FMT_S, FMT_B};
    dec.rd_we    = (dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) &&
                   (in_instr[11:7] != 5'd0) && (in_instr[6:0] != 7'b0001111);
    dec.illegal  = (dec.fmt == FMT_NONE);
  end

  // skid_valid is itself a register, so in_ready never sees out_ready.
  assign in_ready = rst_n && !skid_valid;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      out_q       <= '0;
      out_q.fmt   <= FMT_NONE;
      skid_q      <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid) begin
        out_q       <= skid_q;
        out_valid_q <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign opcode    = out_q.opcode;
  assign funct7    = out_q.funct7;
  assign funct3    = out_q.funct3;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign fmt       = out_q.fmt;
  assign rs1_used  = out_q.rs1_used;
  assign rs2_used  = out_q.rs2_used;
  assign rd_we     = out_q.rd_we;
  assign illegal   = out_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate/datapath width; legal values 32 and 64.
REQ-002 Parameter PC_W, default 32, program-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
REQ-007 in_instr  input  32  raw instruction word.
REQ-008 in_pc  input  PC_W  PC of in_instr.
REQ-009 flush  input  1  discard all held and incoming instructions.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-012 out_pc  output  PC_W  PC of decoded instruction.
REQ-013 opcode/funct7 (7), funct3 (3), rs1/rs2/rd (5)  outputs  raw fields at instr bit positions [6:0], [31:25], [14:12], [19:15], [24:20], [11:7].
REQ-014 imm  output  XLEN  format-selected, sign-extended immediate.
REQ-015 fmt  output  3  0=R,1=I,2=S,3=B,4=U,5=J,7=none/illegal.
REQ-016 rs1_used, rs2_used, rd_we  outputs  1 each  operand/writeback qualifiers.
REQ-017 illegal  output  1  unrecognised instruction.

Function
REQ-018 Decode is combinational on the input word; all outputs are registered; latency in->out is exactly 1 cycle when unblocked.
REQ-019 Buffering: one output register plus one skid register (2 entries total); in_ready = !skid_valid, registered, never combinationally dependent on out_ready.
REQ-020 In-order delivery; no instruction is dropped or duplicated except by flush/reset.
REQ-021 If out_valid && !out_ready and an input transfers, it goes to skid; when output drains, skid moves to output the same edge.
REQ-022 Opcode map: 0110011 R; 0010011, 0000011, 1100111, 1110011, 0001111 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J.
REQ-023 XLEN=64 additionally: 0111011 R, 0011011 I; for XLEN=32 these are illegal.
REQ-024 Immediates: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; U = {instr[31:12],12'b0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended from instr[31] to XLEN; R -> imm=0.
REQ-025 rs1_used=1 for R,I,S,B except U/J and opcode 1110011 with funct3=0; rs2_used=1 for R,S,B only.
REQ-026 rd_we=1 for R,I,U,J when rd!=0, except opcode 0001111 (rd_we=0); rd_we=0 for S,B,illegal.
REQ-027 illegal=1 when instr[1:0]!=2'b11 or opcode unmapped; then fmt=7, imm=0, rs1_used=rs2_used=rd_we=0; raw fields still reported.
REQ-028 flush: next edge clears out_valid and skid_valid; any input transferring that same cycle is discarded; flush overrides simultaneous out transfer (downstream transfer of current output still counts as consumed).
REQ-029 Field outputs hold last value while out_valid=0; content undefined-but-stable, not checked.

Reset
REQ-030 While rst_n=0 at an edge: out_valid=0, skid_valid=0, registered in_ready=1 after the edge; in_ready forced 0 combinationally while rst_n=0.
REQ-031 Reset values: out_pc=0, all field outputs=0, imm=0, fmt=7, illegal=0, rs1_used=rs2_used=rd_we=0.
REQ-032 Reset mid-operation discards both entries; first post-reset accepted instruction appears 1 cycle after acceptance.

Verification
REQ-033 in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, fmt=1, rd=1, rs1=0, imm=0xFFFFFFFF, rd_we=1, rs1_used=1, rs2_used=0.
REQ-034 in_instr=0xFE208EE3 (beq x1,x2,-4) -> fmt=3, imm=0xFFFFFFFC, rs1=1, rs2=2, rd_we=0, rs2_used=1.
REQ-035 Backpressure: out_ready=0, send PC 0x100 then 0x104 back-to-back -> in_ready=0 after second accept; raise out_ready -> 0x100 then 0x104 delivered on consecutive cycles, in_ready=1 again.
REQ-036 Skid full plus flush with in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1, no stale instruction ever emitted.
REQ-037 in_instr=0x00000000 and 0x0000003B (XLEN=32) -> illegal=1, fmt=7, imm=0, rd_we=0; same 0x0000003B with XLEN=64 -> illegal=0, fmt=0.
REQ-038 rst_n=0 for one cycle while both entries full -> out_valid=0, all outputs at REQ-031 values, in_ready=1 the following cycle.
